// File: rtl/sram_sp_init_bw.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sram_sp_init_bw: single-port byte-write SRAM, self-clears after reset      |
// | Option macro: SRAM_SP_INIT_BW_OUT_REG_EN (extra output stage, latency 2)   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sram_sp_init_bw #(
  parameter int BITS       = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int WORD_DEPTH = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         CEN,
  input  logic                         WEN,
  input  logic [BITS/BYTE_WIDTH-1:0]   BWEN,
  input  logic [ADDR_WIDTH-1:0]        A,
  input  logic [BITS-1:0]              D,
  output logic [BITS-1:0]              Q,
  output logic                         BUSY
);

  localparam int LANES = BITS / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  cnt;
  logic                   busy;
  logic [BITS-1:0]        q_stage;
  logic [BITS-1:0]        mem [WORD_DEPTH];

  logic                   in_range;
  logic                   accept;
  logic [BITS-1:0]        old_word;
  logic [BITS-1:0]        merged;

  // Out-of-range addresses behave as a location that always reads zero.
  assign in_range = (32'(A) < 32'(WORD_DEPTH));
  assign old_word = in_range ? mem[A] : '0;
  assign accept   = !busy && !CEN;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign merged[k*BYTE_WIDTH +: BYTE_WIDTH] =
      BWEN[k] ? old_word[k*BYTE_WIDTH +: BYTE_WIDTH] : D[k*BYTE_WIDTH +: BYTE_WIDTH];
  end

  // Storage carries no reset; zeroing happens only through the clear walk.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (accept && !WEN && in_range) begin
        mem[A] <= merged;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= CLEAR;
      cnt     <= '0;
      busy    <= 1'b1;
      q_stage <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ADDR) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          if (accept) begin
            q_stage <= WEN ? old_word : merged;
          end
        end
      endcase
    end
  end

`ifdef SRAM_SP_INIT_BW_OUT_REG_EN
  logic            out_load;
  logic [BITS-1:0] q_out;

  // Second stage only reloads when the first stage took new data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_load <= 1'b0;
      q_out    <= '0;
    end else begin
      out_load <= accept;
      if (out_load) begin
        q_out <= q_stage;
      end
    end
  end

  assign Q = q_out;
`else
  assign Q = q_stage;
`endif

  assign BUSY = busy;

endmodule
`default_nettype wire

// File: tb/tb_sram_sp_init_bw.sv
`default_nettype none
// Scoreboard bench for sram_sp_init_bw: stimulus pushes expected Q values,
// a negedge monitor pops and compares them when they fall due.
`timescale 1ns/1ps
module tb_sram_sp_init_bw;

`ifdef SRAM_SP_INIT_BW_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        CEN;
  logic        WEN;
  logic [3:0]  BWEN;
  logic [9:0]  A;
  logic [31:0] D;
  logic [31:0] Q;
  logic        BUSY;

  sram_sp_init_bw #(
    .BITS(32), .BYTE_WIDTH(8), .WORD_DEPTH(1024), .ADDR_WIDTH(10)
  ) dut (
    .CLK(CLK), .RST(RST), .CEN(CEN), .WEN(WEN), .BWEN(BWEN),
    .A(A), .D(D), .Q(Q), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] val;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: Q is compared against every expectation whose cycle has come.
  exp_t e;
  initial begin
    forever begin
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due < cyc) check($sformatf("q_late_tag%0d", e.tag), 32'(cyc), 32'(e.due));
        else             check($sformatf("q_tag%0d", e.tag), Q, e.val);
      end
    end
  end

  task automatic acc(input logic wen, input logic [9:0] a, input logic [31:0] d,
                     input logic [3:0] bw, input logic [31:0] req, input int tag);
    CEN = 1'b0; WEN = wen; A = a; D = d; BWEN = bw;
    sb.push_back('{cyc + LAT, req, tag});
    @(negedge CLK);
    CEN = 1'b1;
  endtask

  task automatic idle(input logic [31:0] req, input int tag);
    CEN = 1'b1;
    sb.push_back('{cyc + LAT, req, tag});
    @(negedge CLK);
  endtask

  // Presents an access that must be ignored while the clear runs.
  task automatic drive_ignored();
    CEN = 1'b0; WEN = 1'b0; A = 10'd7; D = 32'hFFFF_FFFF; BWEN = 4'b0000;
  endtask

  task automatic clear_wait(input string nm);
    int n = 0;
    bit qz = 1'b1;
    while (BUSY === 1'b1 && n < 2000) begin
      if (Q !== 32'h0) qz = 1'b0;
      n++;
      @(negedge CLK);
    end
    CEN = 1'b1;
    check({nm, "_busy_len"}, 32'(n), 32'd1024);
    check({nm, "_q_zero"}, {31'h0, qz}, 32'h1);
  endtask

  task automatic drain();
    CEN = 1'b1;
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge CLK);
    check("sb_drained", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    RST = 1'b1;
    drive_ignored();
    repeat (2) @(negedge CLK);
    check("rst_q", Q, 32'h0);
    check("rst_busy", {31'h0, BUSY}, 32'h1);
    RST = 1'b0;
    clear_wait("clr1");

    acc(1'b1, 10'h3FF, 32'h0,          4'hF,    32'h0000_0000, 1);
    acc(1'b1, 10'd7,   32'h0,          4'hF,    32'h0000_0000, 2);
    acc(1'b0, 10'd5,   32'hDEAD_BEEF,  4'b0000, 32'hDEAD_BEEF, 3);
    acc(1'b0, 10'd5,   32'h1122_3344,  4'b1010, 32'hDE22_BE44, 4);
    acc(1'b1, 10'd5,   32'h0,          4'hF,    32'hDE22_BE44, 5);
    acc(1'b0, 10'd9,   32'hA5A5_A5A5,  4'b0000, 32'hA5A5_A5A5, 6);
    idle(32'hA5A5_A5A5, 7);
    idle(32'hA5A5_A5A5, 8);
    idle(32'hA5A5_A5A5, 9);
    acc(1'b1, 10'd9,   32'h0,          4'hF,    32'hA5A5_A5A5, 10);
    acc(1'b0, 10'd5,   32'hFFFF_FFFF,  4'b1111, 32'hDE22_BE44, 11);
    acc(1'b1, 10'd5,   32'h0,          4'hF,    32'hDE22_BE44, 12);
    acc(1'b0, 10'd12,  32'h1234_5678,  4'b0000, 32'h1234_5678, 13);
    acc(1'b1, 10'd12,  32'h0,          4'hF,    32'h1234_5678, 14);
    acc(1'b0, 10'd13,  32'hCAFE_F00D,  4'b0101, 32'hCA00_F000, 15);
    acc(1'b1, 10'd13,  32'h0,          4'hF,    32'hCA00_F000, 16);
    drain();

    // Reset arriving together with a write: the write is dropped, Q clears.
    CEN = 1'b0; WEN = 1'b0; A = 10'd5; D = 32'h5555_5555; BWEN = 4'b0000;
    RST = 1'b1;
    @(negedge CLK);
    check("midop_rst_q", Q, 32'h0);
    RST = 1'b0;
    CEN = 1'b1;
    repeat (500) @(negedge CLK);
    check("midclr_busy", {31'h0, BUSY}, 32'h1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    drive_ignored();
    clear_wait("clr2");

    acc(1'b1, 10'd5,   32'h0,          4'hF,    32'h0000_0000, 17);
    acc(1'b1, 10'd9,   32'h0,          4'hF,    32'h0000_0000, 18);
    acc(1'b1, 10'd7,   32'h0,          4'hF,    32'h0000_0000, 19);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
